standoff_round_ctrl: RTL and testbench

STANDOFF_ROUND_CTRL -- requirements
Module: standoff_round_ctrl

---
 rtl/standoff_pkg.sv | 46 ++++
 rtl/standoff_tick_timer.sv | 27 ++
 rtl/standoff_round_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_standoff_round_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/standoff_pkg.sv
// Shared state, action and result codes plus the per-game score record.
// Combinational helpers only; no timing or flow control lives here.
package standoff_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_COLLECT   = 3'd2,
    S_RESOLVE   = 3'd3,
    S_SHOW      = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ACT_RELOAD = 2'd0,
    ACT_SHOOT  = 2'd1,
    ACT_BLOCK  = 2'd2
  } action_t;

  localparam logic [1:0] CHOICE_NONE = 2'd3;

  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_P1_HIT = 2'd1;
  localparam logic [1:0] RES_P2_HIT = 2'd2;
  localparam logic [1:0] RES_NO_HIT = 2'd3;

  typedef struct packed {
    logic [1:0] p1_ammo;
    logic [1:0] p2_ammo;
    logic [1:0] p1_last;
    logic [1:0] p2_last;
    logic [1:0] round_result;
    logic [7:0] round_count;
  } score_t;

  // Shoot is only ever passed here once it is known to be effective (ammo > 0).
  function automatic logic [1:0] next_ammo(input logic [1:0] ammo, input action_t act,
                                           input logic [1:0] ammo_max);
    case (act)
      ACT_RELOAD: return (ammo < ammo_max) ? ammo + 2'd1 : ammo_max;
      ACT_SHOOT:  return ammo - 2'd1;
      default:    return ammo;
    endcase
  endfunction

endpackage

// File: rtl/standoff_tick_timer.sv
// Elapsed-cycle timer: start marks the first cycle of a period, done flags its last cycle.
// Zero latency on start (that cycle counts as elapsed 0); no backpressure.
module standoff_tick_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;
  logic [W-1:0] elapsed;

  assign elapsed = start ? '0 : cnt;
  assign done    = (elapsed == limit - W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= elapsed + W'(1);
    end
  end

endmodule

// File: rtl/standoff_round_ctrl.sv
// Two-player standoff round FSM: countdown, choice window, one-cycle resolve, timed show.
// Resolves one cycle after both choices latch; no backpressure, strobes outside COLLECT are dropped.
module standoff_round_ctrl
  import standoff_pkg::*;
#(
  parameter int TICKS_PER_STEP = 50000000,
  parameter int COUNT_STEPS    = 3,
  parameter int WINDOW_TICKS   = 100000000,
  parameter int SHOW_TICKS     = 100000000,
  parameter int AMMO_MAX       = 3
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       p1_key_valid,
  input  logic [1:0] p1_choice,
  input  logic       p2_key_valid,
  input  logic [1:0] p2_choice,
  input  logic       restart_req,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [1:0] p1_ammo,
  output logic [1:0] p2_ammo,
  output logic [1:0] p1_last,
  output logic [1:0] p2_last,
  output logic [1:0] round_result,
  output logic       result_valid,
  output logic       game_over,
  output logic [7:0] round_count
);

  localparam logic [31:0] STEP_L   = 32'(TICKS_PER_STEP);
  localparam logic [31:0] WINDOW_L = 32'(WINDOW_TICKS);
  localparam logic [31:0] SHOW_L   = 32'(SHOW_TICKS);
  localparam logic [1:0]  COUNT_L  = 2'(COUNT_STEPS);
  localparam logic [1:0]  AMMO_L   = 2'(AMMO_MAX);

  logic [1:0]  rst_sync;
  logic        rst_n;
  state_t      state_q;
  score_t      score;
  action_t     p1_sel, p2_sel, p1_eff, p2_eff;
  logic        p1_got, p2_got, p1_take, p2_take, both_in;
  logic [1:0]  res_next;
  logic        tmr_start, tmr_done;
  logic [31:0] tmr_limit;

  // Assert passes straight through; release is delayed two edges.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) rst_sync <= '0;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_comb begin
    tmr_limit = STEP_L;
    case (state_q)
      S_COLLECT: tmr_limit = WINDOW_L;
      S_SHOW:    tmr_limit = SHOW_L;
      default:   tmr_limit = STEP_L;
    endcase
  end

  standoff_tick_timer #(.W(32)) u_timer (
    .clk   (CLK100MHZ),
    .rst_n (rst_n),
    .start (tmr_start),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  assign p1_take = p1_key_valid && !p1_got && (p1_choice != CHOICE_NONE);
  assign p2_take = p2_key_valid && !p2_got && (p2_choice != CHOICE_NONE);
  assign both_in = (p1_got || p1_take) && (p2_got || p2_take);

  // Unlatched players already hold ACT_BLOCK from COLLECT entry; a dry shoot misfires as block.
  always_comb begin
    p1_eff   = (p1_sel == ACT_SHOOT && score.p1_ammo == 2'd0) ? ACT_BLOCK : p1_sel;
    p2_eff   = (p2_sel == ACT_SHOOT && score.p2_ammo == 2'd0) ? ACT_BLOCK : p2_sel;
    res_next = RES_NO_HIT;
    if (p1_eff == ACT_SHOOT && p2_eff == ACT_SHOOT)      res_next = RES_NO_HIT;
    else if (p1_eff == ACT_SHOOT && p2_eff != ACT_BLOCK) res_next = RES_P1_HIT;
    else if (p2_eff == ACT_SHOOT && p1_eff != ACT_BLOCK) res_next = RES_P2_HIT;
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      countdown    <= '0;
      score        <= '0;
      result_valid <= 1'b0;
      game_over    <= 1'b0;
      p1_got       <= 1'b0;
      p2_got       <= 1'b0;
      p1_sel       <= ACT_RELOAD;
      p2_sel       <= ACT_RELOAD;
      tmr_start    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      tmr_start    <= 1'b0;
      if (restart_req && (state_q == S_COUNTDOWN || state_q == S_COLLECT || state_q == S_SHOW)) begin
        state_q   <= S_IDLE;
        countdown <= '0;
        score     <= '0;
        p1_got    <= 1'b0;
        p2_got    <= 1'b0;
        p1_sel    <= ACT_RELOAD;
        p2_sel    <= ACT_RELOAD;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (restart_req) begin
              state_q   <= S_COUNTDOWN;
              countdown <= COUNT_L;
              tmr_start <= 1'b1;
            end
          end
          S_COUNTDOWN: begin
            if (tmr_done) begin
              tmr_start <= 1'b1;
              countdown <= countdown - 2'd1;
              if (countdown == 2'd1) begin
                state_q <= S_COLLECT;
                p1_got  <= 1'b0;
                p2_got  <= 1'b0;
                p1_sel  <= ACT_BLOCK;
                p2_sel  <= ACT_BLOCK;
              end
            end
          end
          S_COLLECT: begin
            if (p1_take) begin
              p1_got <= 1'b1;
              p1_sel <= action_t'(p1_choice);
            end
            if (p2_take) begin
              p2_got <= 1'b1;
              p2_sel <= action_t'(p2_choice);
            end
            if (both_in || tmr_done) state_q <= S_RESOLVE;
          end
          S_RESOLVE: begin
            score.p1_ammo      <= next_ammo(score.p1_ammo, p1_eff, AMMO_L);
            score.p2_ammo      <= next_ammo(score.p2_ammo, p2_eff, AMMO_L);
            score.p1_last      <= p1_eff;
            score.p2_last      <= p2_eff;
            score.round_result <= res_next;
            score.round_count  <= (score.round_count == 8'hFF) ? 8'hFF : score.round_count + 8'd1;
            result_valid       <= 1'b1;
            state_q            <= S_SHOW;
            tmr_start          <= 1'b1;
          end
          S_SHOW: begin
            if (tmr_done) begin
              if (score.round_result == RES_P1_HIT || score.round_result == RES_P2_HIT) begin
                state_q   <= S_GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state_q   <= S_COUNTDOWN;
                countdown <= COUNT_L;
                tmr_start <= 1'b1;
              end
            end
          end
          S_GAME_OVER: begin
            if (restart_req) begin
              score     <= '0;
              game_over <= 1'b0;
              state_q   <= S_COUNTDOWN;
              countdown <= COUNT_L;
              tmr_start <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign state        = state_q;
  assign p1_ammo      = score.p1_ammo;
  assign p2_ammo      = score.p2_ammo;
  assign p1_last      = score.p1_last;
  assign p2_last      = score.p2_last;
  assign round_result = score.round_result;
  assign round_count  = score.round_count;

endmodule

// File: tb/tb_standoff_round_ctrl.sv
// Directed bench for standoff_round_ctrl with a per-cycle reference model of the game rules.
module tb_standoff_round_ctrl;

  localparam int TPS = 4, STEPS = 3, WIN = 10, SHOWT = 5, AMAX = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       p1_kv = 1'b0, p2_kv = 1'b0, restart = 1'b0;
  logic [1:0] p1_ch = 2'd0, p2_ch = 2'd0;
  logic [2:0] state;
  logic [1:0] countdown, p1_ammo, p2_ammo, p1_last, p2_last, round_result;
  logic       result_valid, game_over;
  logic [7:0] round_count;

  standoff_round_ctrl #(
    .TICKS_PER_STEP(TPS), .COUNT_STEPS(STEPS), .WINDOW_TICKS(WIN),
    .SHOW_TICKS(SHOWT), .AMMO_MAX(AMAX)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rstn),
    .p1_key_valid(p1_kv), .p1_choice(p1_ch),
    .p2_key_valid(p2_kv), .p2_choice(p2_ch),
    .restart_req(restart),
    .state(state), .countdown(countdown),
    .p1_ammo(p1_ammo), .p2_ammo(p2_ammo),
    .p1_last(p1_last), .p2_last(p2_last),
    .round_result(round_result), .result_valid(result_valid),
    .game_over(game_over), .round_count(round_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: phase plus cycles left in the phase, players as plain ints (-1 = no key yet).
  int m_state = 0, m_cd = 0, m_left = 0, m_sync = 0;
  int a1 = 0, a2 = 0, l1 = 0, l2 = 0, res = 0, rc = 0, c1 = -1, c2 = -1;
  int rv = 0, go = 0;

  function automatic void m_reset();
    m_state = 0; m_cd = 0; m_left = 0; m_sync = 0;
    a1 = 0; a2 = 0; l1 = 0; l2 = 0; res = 0; rc = 0; c1 = -1; c2 = -1;
    rv = 0; go = 0;
  endfunction

  function automatic void m_clear_game();
    a1 = 0; a2 = 0; l1 = 0; l2 = 0; res = 0; rc = 0; c1 = -1; c2 = -1; m_cd = 0;
  endfunction

  function automatic void m_new_round();
    m_state = 1; m_cd = STEPS; m_left = TPS;
  endfunction

  function automatic void m_resolve();
    int e1, e2;
    e1 = (c1 < 0) ? 2 : c1;
    e2 = (c2 < 0) ? 2 : c2;
    if (e1 == 1 && a1 == 0) e1 = 2;
    if (e2 == 1 && a2 == 0) e2 = 2;
    if (e1 == 1 && e2 == 1)      res = 3;
    else if (e1 == 1 && e2 != 2) res = 1;
    else if (e2 == 1 && e1 != 2) res = 2;
    else                         res = 3;
    if (e1 == 0) a1 = (a1 + 1 > AMAX) ? AMAX : a1 + 1;
    if (e1 == 1) a1 = a1 - 1;
    if (e2 == 0) a2 = (a2 + 1 > AMAX) ? AMAX : a2 + 1;
    if (e2 == 1) a2 = a2 - 1;
    l1 = e1; l2 = e2;
    rc = (rc >= 255) ? 255 : rc + 1;
  endfunction

  function automatic void m_step();
    rv = 0;
    if (restart && (m_state == 1 || m_state == 2 || m_state == 4)) begin
      m_state = 0; m_clear_game();
      return;
    end
    case (m_state)
      0: if (restart) m_new_round();
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_cd--;
          m_left = TPS;
          if (m_cd == 0) begin m_state = 2; m_left = WIN; c1 = -1; c2 = -1; end
        end
      end
      2: begin
        if (p1_kv && c1 < 0 && p1_ch != 2'd3) c1 = int'(p1_ch);
        if (p2_kv && c2 < 0 && p2_ch != 2'd3) c2 = int'(p2_ch);
        m_left--;
        if ((c1 >= 0 && c2 >= 0) || m_left == 0) m_state = 3;
      end
      3: begin m_resolve(); rv = 1; m_state = 4; m_left = SHOWT; end
      4: begin
        m_left--;
        if (m_left == 0) begin
          if (res == 1 || res == 2) begin m_state = 5; go = 1; end
          else m_new_round();
        end
      end
      5: if (restart) begin m_clear_game(); go = 0; m_new_round(); end
      default: m_state = 0;
    endcase
  endfunction

  always @(negedge rstn) m_reset();

  always @(posedge clk) begin
    if (!rstn)           m_reset();
    else if (m_sync < 2) m_sync++;
    else                 m_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_state", state, m_state);
      check("m_countdown", countdown, m_cd);
      check("m_p1_ammo", p1_ammo, a1);
      check("m_p2_ammo", p2_ammo, a2);
      check("m_p1_last", p1_last, l1);
      check("m_p2_last", p2_last, l2);
      check("m_round_result", round_result, res);
      check("m_result_valid", result_valid, rv);
      check("m_game_over", game_over, go);
      check("m_round_count", round_count, rc);
    end
  end

  task automatic keys(input bit v1, input logic [1:0] ch1, input bit v2, input logic [1:0] ch2);
    p1_kv = v1; p1_ch = ch1; p2_kv = v2; p2_ch = ch2;
    @(posedge clk); #1;
    p1_kv = 1'b0; p2_kv = 1'b0; p1_ch = 2'd0; p2_ch = 2'd0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic wait_state(input int code, input int budget, output int n);
    n = 0;
    while (int'(state) != code && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("reach_state_%0d", code), state, code);
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk); #1;
    check("reset_state", state, 0);
    check("reset_ammo", p1_ammo, 0);
    check("reset_round_count", round_count, 0);
    cmp_en = 1'b1;
    rstn = 1'b1;
    repeat (3) @(posedge clk); #1;

    keys(1, 2'd0, 0, 2'd0);
    check("idle_ignores_keys", state, 0);
    do_restart();
    check("countdown_entry_state", state, 1);
    check("countdown_entry_value", countdown, 3);
    keys(1, 2'd1, 1, 2'd0);
    repeat (3) @(posedge clk); #1;
    check("countdown_second_step", countdown, 2);
    wait_state(2, 20, n);
    check("countdown_total_cycles", n + 4, 12);
    check("no_preload_ammo", p1_ammo, 0);

    // Both reload in the same cycle.
    keys(1, 2'd0, 1, 2'd0);
    check("resolve_next_cycle", state, 3);
    @(posedge clk); #1;
    check("r1_valid", result_valid, 1);
    check("r1_p1_ammo", p1_ammo, 1);
    check("r1_p2_ammo", p2_ammo, 1);
    check("r1_result", round_result, 3);
    check("r1_count", round_count, 1);
    wait_state(1, 20, n);
    check("show_cycles", n + 1, 6);

    // P1 shoots, P2 silent until the window closes.
    wait_state(2, 20, n);
    keys(1, 2'd1, 0, 2'd0);
    wait_state(3, 20, n);
    check("window_cycles", n + 1, WIN);
    @(posedge clk); #1;
    check("r2_p1_ammo", p1_ammo, 0);
    check("r2_p2_last", p2_last, 2);
    check("r2_result", round_result, 3);
    wait_state(1, 20, n);

    // P1 misfires on empty, P2 reloads.
    wait_state(2, 20, n);
    keys(1, 2'd1, 1, 2'd0);
    @(posedge clk); #1;
    check("r3_p1_last_misfire", p1_last, 2);
    check("r3_result", round_result, 3);
    check("r3_p2_ammo", p2_ammo, 2);
    wait_state(1, 20, n);

    // P2 shoots a reloading P1.
    wait_state(2, 20, n);
    keys(1, 2'd0, 1, 2'd1);
    @(posedge clk); #1;
    check("r4_result", round_result, 2);
    check("r4_p2_ammo", p2_ammo, 1);
    wait_state(5, 20, n);
    check("r4_game_over", game_over, 1);
    repeat (4) @(posedge clk); #1;
    check("game_over_holds", state, 5);
    check("game_over_result_holds", round_result, 2);
    do_restart();
    check("restart_go_state", state, 1);
    check("restart_go_p2_ammo", p2_ammo, 0);
    check("restart_go_count", round_count, 0);
    check("restart_go_result", round_result, 0);
    check("restart_go_flag", game_over, 0);

    // Ammo saturation; extra P1 strobe and P2 choice 3 ignored in the first window.
    for (int r = 0; r < 5; r++) begin
      wait_state(2, 30, n);
      keys(1, 2'd0, 0, 2'd0);
      if (r == 0) keys(1, 2'd1, 1, 2'd3);
      keys(0, 2'd0, 1, 2'd2);
      @(posedge clk); #1;
      check($sformatf("sat_p1_ammo_%0d", r), p1_ammo, (r + 1 > 3) ? 3 : r + 1);
      check($sformatf("sat_p1_last_%0d", r), p1_last, 0);
      wait_state(1, 20, n);
    end
    check("sat_round_count", round_count, 5);

    // Abort from COLLECT.
    wait_state(2, 30, n);
    keys(1, 2'd0, 0, 2'd0);
    do_restart();
    check("abort_state", state, 0);
    check("abort_ammo", p1_ammo, 0);
    check("abort_count", round_count, 0);

    // Restart during RESOLVE is ignored; then reset mid-SHOW.
    do_restart();
    wait_state(2, 30, n);
    keys(1, 2'd0, 1, 2'd0);
    do_restart();
    check("resolve_ignores_restart", state, 4);
    check("resolve_p1_ammo", p1_ammo, 1);
    rstn = 1'b0;
    #1;
    check("async_reset_state", state, 0);
    check("async_reset_ammo", p1_ammo, 0);
    check("async_reset_count", round_count, 0);
    check("async_reset_valid", result_valid, 0);
    check("async_reset_last", p2_last, 0);
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("post_reset_idle", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
